// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned multiplier that time-shares one 4x4 Vedic core over four nibble steps.
// Optional VEDIC_ZERO_SKIP_EN: zero operands bypass the core and complete one cycle after accept.

module vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;

    // Urdhva-Tiryagbhyam: vertical, crosswise, vertical
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
endmodule

module Vedic4x4_Top (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;

    vedic2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    assign p = {4'h0, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'h0};
endmodule

module vedic_mul8_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      product,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  step;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc;
    logic [3:0]  core_a;
    logic [3:0]  core_b;
    logic [7:0]  core_p;
    logic [15:0] partial;

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign core_a = step[0] ? a_r[7:4] : a_r[3:0];
    assign core_b = step[1] ? b_r[7:4] : b_r[3:0];

    Vedic4x4_Top u_core (.a(core_a), .b(core_b), .p(core_p));

    always_comb begin
        partial = 16'h0000;
        case (step)
            2'd0:    partial = {8'h00, core_p};
            2'd1,
            2'd2:    partial = {4'h0, core_p, 4'h0};
            default: partial = {core_p, 8'h00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 2'd0;
            a_r      <= 8'h00;
            b_r      <= 8'h00;
            acc      <= 16'h0000;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        acc  <= 16'h0000;
                        step <= 2'd0;
`ifdef VEDIC_ZERO_SKIP_EN
                        if (a == 8'h00 || b == 8'h00) state <= DONE;
                        else                          state <= CALC;
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc  <= acc + partial;
                    step <= step + 2'd1;
                    if (step == 2'd3) state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        op_count <= op_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;
endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Self-checking bench for vedic_mul8_seq: reference products from plain a*b, latency from the operand rule.
// Second instance with CNT_W=2 exercises counter wrap.

module tb_vedic_mul8_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic [7:0]  op_count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  a2 = 8'h00;
    logic [7:0]  b2 = 8'h00;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [15:0] product2;
    logic [1:0]  op_count2;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_p;
    logic [7:0]  exp_count = 8'h00;
    int          exp_lat;

    vedic_mul8_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .op_count(op_count)
    );

    vedic_mul8_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .product(product2), .op_count(op_count2)
    );

    always #5 clk = ~clk;

    function automatic int model_latency(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_ZERO_SKIP_EN
        if (x == 8'h00 || y == 8'h00) return 1;
`endif
        return 4;
    endfunction

    // Drivers: all start and end at 1 time unit after a rising edge.
    task automatic send_op(input logic [7:0] x, input logic [7:0] y);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        exp_q.push_back(16'(x) * 16'(y));
        exp_lat = model_latency(x, y);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic take_product();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count = exp_count + 8'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || product !== 16'h0000 || op_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%b product=%h op_count=%h, required 0/0000/00",
                     out_valid, product, op_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_max();
        int lat;
        out_ready = 1'b1;
        send_op(8'hFF, 8'hFF);
        wait_valid(lat);
        exp_p = exp_q.pop_front();
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL max_latency: got %0d required 4", lat);
        end
        n_checks++;
        if (product !== exp_p || product !== 16'hFE01) begin
            n_fail++;
            $display("FAIL max_product: got %h required %h", product, exp_p);
        end
        @(posedge clk); #1;
        exp_count = exp_count + 8'd1;
        out_ready = 1'b0;
        n_checks++;
        if (op_count !== exp_count || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL max_handshake: op_count=%h in_ready=%b out_valid=%b, required %h/1/0",
                     op_count, in_ready, out_valid, exp_count);
        end
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        send_op(8'h12, 8'h34);
        in_valid = 1'b1;
        a = 8'(($urandom_range(1, 255)));
        b = 8'(($urandom_range(1, 255)));
        wait_valid(lat);
        exp_p = exp_q.pop_front();
        n_checks++;
        if (product !== exp_p || product !== 16'h03A8) begin
            n_fail++;
            $display("FAIL stall_product: got %h required %h", product, exp_p);
        end
        for (int i = 0; i < 3; i++) begin
            a = 8'(($urandom_range(1, 255)));
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp_p) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b product=%h, required 1/0/%h",
                         i, out_valid, in_ready, product, exp_p);
            end
        end
        in_valid = 1'b0;
        take_product();
        n_checks++;
        if (op_count !== exp_count || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: op_count=%h in_ready=%b, required %h/1", op_count, in_ready, exp_count);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_queue: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero();
        int lat;
        send_op(8'h00, 8'hAB);
        wait_valid(lat);
        exp_p = exp_q.pop_front();
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d required %0d", lat, exp_lat);
        end
        n_checks++;
        if (product !== exp_p) begin
            n_fail++;
            $display("FAIL zero_product: got %h required %h", product, exp_p);
        end
        take_product();
        n_checks++;
        if (op_count !== exp_count) begin
            n_fail++;
            $display("FAIL zero_count: got %h required %h", op_count, exp_count);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int seen = 0;
        send_op(8'h9C, 8'h5A);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_count = 8'h00;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || product !== 16'h0000 || op_count !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_reset: out_valid=%b product=%h op_count=%h in_ready=%b, required 0/0000/00/1",
                     out_valid, product, op_count, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || op_count !== 8'h00) begin
            n_fail++;
            $display("FAIL midop_abandon: valid cycles=%0d op_count=%h, required 0/00", seen, op_count);
        end
        out_ready = 1'b0;
        send_op(8'h03, 8'h05);
        wait_valid(lat);
        exp_p = exp_q.pop_front();
        n_checks++;
        if (lat != 4 || product !== exp_p) begin
            n_fail++;
            $display("FAIL midop_next: latency=%0d product=%h, required 4/%h", lat, product, exp_p);
        end
        take_product();
        n_checks++;
        if (op_count !== exp_count) begin
            n_fail++;
            $display("FAIL midop_count: got %h required %h", op_count, exp_count);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] x, y;
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            if (i % 8 == 3) x = 8'h00;
            if (i % 8 == 6) y = 8'h00;
            send_op(x, y);
            wait_valid(lat);
            exp_p = exp_q.pop_front();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            n_checks++;
            if (lat != exp_lat || product !== exp_p || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d] %h*%h: latency=%0d product=%h out_valid=%b, required %0d/%h/1",
                         i, x, y, lat, product, out_valid, exp_lat, exp_p);
            end
            take_product();
            n_checks++;
            if (op_count !== exp_count) begin
                n_fail++;
                $display("FAIL random_count[%0d]: got %h required %h", i, op_count, exp_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seq[4] = '{1, 2, 3, 0};
        int waited;
        in_valid2 = 1'b1;
        a2 = 8'h01;
        b2 = 8'h01;
        out_ready2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (!out_valid2 && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            n_checks++;
            if (out_valid2 !== 1'b1 || product2 !== 16'h0001) begin
                n_fail++;
                $display("FAIL b2b_product[%0d]: out_valid=%b product=%h, required 1/0001", k, out_valid2, product2);
            end
            @(posedge clk); #1;
            n_checks++;
            if (op_count2 !== 2'(seq[k])) begin
                n_fail++;
                $display("FAIL b2b_count[%0d]: got %0d required %0d", k, op_count2, seq[k]);
            end
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max();
        test_stall();
        test_zero();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vedic_mul8_seq.md
VEDIC_MUL8_SEQ -- requirements
Module: vedic_mul8_seq

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of completed-operation counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands.
REQ-006 SHALL have port: a  input  8  unsigned multiplicand.
REQ-007 SHALL have port: b  input  8  unsigned multiplier.
REQ-008 SHALL have port: out_valid  output  1  product available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes product.
REQ-010 SHALL have port: product  output  16  unsigned a*b.
REQ-011 SHALL have port: op_count  output  CNT_W  completed output handshakes, modulo 2^CNT_W.

Function
REQ-012 SHALL compute the 8x8 product by time-sharing exactly one instance of the team's 4x4 Vedic multiplier core (Vedic4x4_Top), with no other multiplier.
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; only IDLE asserts in_ready; only DONE asserts out_valid.
REQ-014 SHALL accept operands on a clock edge where in_valid && in_ready, registering a and b and clearing the 16-bit accumulator; transitions: IDLE->CALC with step=0.
REQ-015 SHALL, in CALC, drive the core with one nibble pair per cycle and add its result to the accumulator at the edge: step0 aL*bL <<0, step1 aH*bL <<4, step2 aL*bH <<4, step3 aH*bH <<8.
REQ-016 SHALL move CALC->DONE on the step3 edge; out_valid rises after the 4th edge following the accept edge (latency 4 cycles).
REQ-017 SHALL present product = accumulator, stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-018 SHALL, on an edge with out_valid && out_ready, move DONE->IDLE and increment op_count (wrapping to 0 after 2^CNT_W-1); in_ready rises the following cycle.
REQ-019 SHALL ignore a, b and in_valid while in CALC or DONE (no overlap, no queuing).
REQ-020 SHALL hold the accumulator width at 16 bits; no intermediate sum exceeds 0xFE01, so no overflow handling exists.
REQ-021 SHALL ignore out_ready outside DONE.

Reset
REQ-022 SHALL, on rst_n low, immediately force state IDLE, step=0, accumulator=0, operand registers=0, op_count=0, product=0x0000, out_valid=0, in_ready=1 (after release).
REQ-023 SHALL abandon any in-flight operation on reset with no product ever emitted for it.
REQ-024 SHALL begin accepting on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro VEDIC_ZERO_SKIP_EN.
REQ-026 SHALL, with VEDIC_ZERO_SKIP_EN defined, on an accept edge where a==0 or b==0, go IDLE->DONE directly with product 0x0000 (latency 1 cycle), the core unused.
REQ-027 SHALL, without VEDIC_ZERO_SKIP_EN, process zero operands through all four CALC steps (latency 4), yielding 0x0000.

Verification
REQ-028 SHALL cover: a=0xFF, b=0xFF, out_ready=1 -> out_valid after 4 cycles, product=0xFE01, op_count=1, in_ready next cycle.
REQ-029 SHALL cover: a=0x12, b=0x34, out_ready held 0 for 3 cycles in DONE -> product=0x03A8 held constant, in_ready=0 throughout, new in_valid ignored.
REQ-030 SHALL cover: a=0x00, b=0xAB -> product=0x0000; out_valid after 1 cycle with VEDIC_ZERO_SKIP_EN, after 4 cycles without.
REQ-031 SHALL cover: a=0x9C, b=0x5A accepted, rst_n pulsed low during step2 -> out_valid=0, product=0x0000, op_count=0, no completion; next op 0x03*0x05 -> 0x000F.
REQ-032 SHALL cover: CNT_W=2, four back-to-back ops 0x01*0x01 -> op_count sequence 1,2,3,0, each product=0x0001.
